// File: rtl/pll_cfg_shifter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_cfg_shifter_if                                           |
// | Description : Control and serial-pin bundle for the PLL config shifter.    |
// |               The master side requests transactions and plays the PLL;     |
// |               the slave side is the shifter itself.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface pll_cfg_shifter_if #(
  parameter int CFG_WIDTH = 30
);
  logic                 start;
  logic [CFG_WIDTH-1:0] cfg_data;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic [CFG_WIDTH-1:0] rdata;
  logic                 sclk;
  logic                 sdi;
  logic                 sdo;
  logic                 pll_resetb;
  logic                 lock;

  modport master (
    output start, cfg_data, sdo, lock,
    input  busy, done, error, rdata, sclk, sdi, pll_resetb
  );

  modport slave (
    input  start, cfg_data, sdo, lock,
    output busy, done, error, rdata, sclk, sdi, pll_resetb
  );
endinterface
`default_nettype wire

// File: rtl/pll_cfg_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pll_cfg_shifter                                              |
// | Description : Holds the PLL in reset, shifts a configuration word in MSB   |
// |               first while reading the old word back, releases reset and   |
// |               waits (with timeout) for the PLL to report lock.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pll_cfg_shifter #(
  parameter int CFG_WIDTH    = 30,
  parameter int SCLK_DIV     = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pll_cfg_shifter_if.slave bus
);

  localparam int HALF_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int WAIT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);
  // Seven bits cover word lengths up to 64.
  localparam logic [6:0]        BIT_LAST  = 7'(CFG_WIDTH - 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RST_ASSERT = 3'd1;
  localparam logic [2:0] ST_SHIFT      = 3'd2;
  localparam logic [2:0] ST_RELEASE    = 3'd3;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd4;
  localparam logic [2:0] ST_FINISH     = 3'd5;

  logic [2:0]           state;
  logic [HALF_W-1:0]    half_cnt;
  logic                 phase_high;
  logic [6:0]           bit_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic [CFG_WIDTH-1:0] cfg_sr;
  logic [CFG_WIDTH-1:0] rdata;
  logic                 busy;
  logic                 done;
  logic                 error;
  logic                 sclk;
  logic                 sdi;
  logic                 pll_resetb;
  logic                 lock_meta;
  logic                 lock_sync;

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.rdata      = rdata;
  assign bus.sclk       = sclk;
  assign bus.sdi        = sdi;
  assign bus.pll_resetb = pll_resetb;

  // Two-flop synchronizer bringing the asynchronous PLL lock into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= bus.lock;
      lock_sync <= lock_meta;
    end
  end

  // Transaction sequencer; every PLL-facing pin comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      half_cnt   <= '0;
      phase_high <= 1'b0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      cfg_sr     <= '0;
      rdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      sclk       <= 1'b0;
      sdi        <= 1'b0;
      pll_resetb <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        // FINISH also samples START so a held request restarts with no idle gap.
        ST_IDLE, ST_FINISH: begin
          if (bus.start) begin
            cfg_sr     <= bus.cfg_data;
            error      <= 1'b0;
            rdata      <= '0;
            busy       <= 1'b1;
            pll_resetb <= 1'b0;
            half_cnt   <= '0;
            state      <= ST_RST_ASSERT;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_RST_ASSERT: begin
          if (half_cnt == HALF_LAST) begin
            // First low phase starts here, so the MSB goes out now.
            half_cnt   <= '0;
            phase_high <= 1'b0;
            bit_cnt    <= '0;
            sdi        <= cfg_sr[CFG_WIDTH-1];
            cfg_sr     <= cfg_sr << 1;
            state      <= ST_SHIFT;
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end

        ST_SHIFT: begin
          if (half_cnt != HALF_LAST) begin
            half_cnt <= half_cnt + HALF_W'(1);
          end else begin
            half_cnt <= '0;
            if (!phase_high) begin
              // Rising SCLK: capture the PLL's current SDO bit at the same edge.
              phase_high <= 1'b1;
              sclk       <= 1'b1;
              rdata      <= (rdata << 1) | CFG_WIDTH'(bus.sdo);
            end else begin
              phase_high <= 1'b0;
              sclk       <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                sdi   <= 1'b0;
                state <= ST_RELEASE;
              end else begin
                bit_cnt <= bit_cnt + 7'd1;
                sdi     <= cfg_sr[CFG_WIDTH-1];
                cfg_sr  <= cfg_sr << 1;
              end
            end
          end
        end

        ST_RELEASE: begin
          if (half_cnt == HALF_LAST) begin
            pll_resetb <= 1'b1;
            wait_cnt   <= '0;
            state      <= ST_WAIT_LOCK;
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          // Lock is tested first so it beats a simultaneous timeout.
          if (lock_sync) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b0;
            state <= ST_FINISH;
          end else if (wait_cnt == WAIT_LAST) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ST_FINISH;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_cfg_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pll_cfg_shifter                                           |
// | Description : Three shifter instances (default, short timeout, 1-bit)      |
// |               checked each cycle against a transaction-level model, with   |
// |               a PLL shift-register model answering on SDO.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pll_cfg_shifter;

  logic clk;
  logic rst;

  logic        start_v [3];
  logic [63:0] cfg_v   [3];
  logic        lock_v  [3];
  logic [63:0] pll_sr  [3];

  int pw [3] = '{30, 8, 1};
  int pd [3] = '{4, 2, 1};
  int pt [3] = '{1024, 16, 4};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pll_cfg_shifter_if #(.CFG_WIDTH(30)) if_a ();
  pll_cfg_shifter_if #(.CFG_WIDTH(8))  if_b ();
  pll_cfg_shifter_if #(.CFG_WIDTH(1))  if_c ();

  pll_cfg_shifter #(.CFG_WIDTH(30), .SCLK_DIV(4), .LOCK_TIMEOUT(1024)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  pll_cfg_shifter #(.CFG_WIDTH(8), .SCLK_DIV(2), .LOCK_TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));
  pll_cfg_shifter #(.CFG_WIDTH(1), .SCLK_DIV(1), .LOCK_TIMEOUT(4)) dut_c (
    .clk(clk), .rst(rst), .bus(if_c.slave));

  assign if_a.start    = start_v[0];
  assign if_a.cfg_data = cfg_v[0][29:0];
  assign if_a.lock     = lock_v[0];
  assign if_a.sdo      = pll_sr[0][29];
  assign if_b.start    = start_v[1];
  assign if_b.cfg_data = cfg_v[1][7:0];
  assign if_b.lock     = lock_v[1];
  assign if_b.sdo      = pll_sr[1][7];
  assign if_c.start    = start_v[2];
  assign if_c.cfg_data = cfg_v[2][0:0];
  assign if_c.lock     = lock_v[2];
  assign if_c.sdo      = pll_sr[2][0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- helpers
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mask(input int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  // {busy, done, error, sclk, sdi, pll_resetb}
  function automatic logic [5:0] get_out(input int d);
    case (d)
      0:       return {if_a.busy, if_a.done, if_a.error, if_a.sclk, if_a.sdi, if_a.pll_resetb};
      1:       return {if_b.busy, if_b.done, if_b.error, if_b.sclk, if_b.sdi, if_b.pll_resetb};
      default: return {if_c.busy, if_c.done, if_c.error, if_c.sclk, if_c.sdi, if_c.pll_resetb};
    endcase
  endfunction

  function automatic logic [63:0] get_rd(input int d);
    case (d)
      0:       return 64'(if_a.rdata);
      1:       return 64'(if_b.rdata);
      default: return 64'(if_c.rdata);
    endcase
  endfunction

  // ---------------------------------------------------------------- model
  // A transaction is described by k = cycles since the accepting edge; the
  // expected pins follow from where k falls in the reset/shift/release plan.
  bit          act_m [3];
  bit          fin_m [3];
  int          k_m   [3];
  logic [63:0] word_m[3];
  logic [63:0] exp_rd[3];
  logic [63:0] rd_m  [3];
  bit          err_m [3];
  bit          ls1_m [3];
  bit          ls2_m [3];

  int sclk_rises[3], sclk_high[3], sdi_high[3], rb_low[3], rb_rises[3];
  int done_cnt[3], done_cyc[3], rise_cyc[3], busy_low[3];
  bit prev_sclk[3], prev_rb[3];

  task automatic model_step(input int d);
    int  wl;
    bit  l2;
    wl = 2 * pd[d] + 2 * pw[d] * pd[d];
    l2 = ls2_m[d];
    if (rst) begin
      act_m[d] = 0; fin_m[d] = 0; k_m[d] = 0; err_m[d] = 0;
      rd_m[d] = '0; ls1_m[d] = 0; ls2_m[d] = 0;
    end else begin
      ls2_m[d] = ls1_m[d];
      ls1_m[d] = lock_v[d];
      if (!act_m[d] || fin_m[d]) begin
        fin_m[d] = 0;
        if (start_v[d]) begin
          act_m[d]  = 1;
          k_m[d]    = 0;
          word_m[d] = cfg_v[d] & mask(pw[d]);
          exp_rd[d] = pll_sr[d] & mask(pw[d]);
          err_m[d]  = 0;
          rd_m[d]   = '0;
        end else begin
          act_m[d] = 0;
        end
      end else if (k_m[d] >= wl) begin
        if (l2) begin
          fin_m[d] = 1; rd_m[d] = exp_rd[d];
        end else if (k_m[d] - wl == pt[d] - 1) begin
          fin_m[d] = 1; err_m[d] = 1; rd_m[d] = exp_rd[d];
        end else begin
          k_m[d]++;
        end
      end else begin
        k_m[d]++;
      end
    end
  endtask

  function automatic logic [5:0] model_out(input int d);
    int   w, dv, s, b, p;
    logic sc, sd, rb, bz, dn;
    w = pw[d]; dv = pd[d];
    sc = 0; sd = 0; rb = 1; bz = 0; dn = 0;
    if (fin_m[d]) begin
      dn = 1;
    end else if (act_m[d]) begin
      bz = 1;
      rb = 0;
      if (k_m[d] >= dv && k_m[d] < dv + 2 * w * dv) begin
        s  = k_m[d] - dv;
        b  = s / (2 * dv);
        p  = s % (2 * dv);
        sc = (p >= dv);
        sd = word_m[d][w - 1 - b];
      end else if (k_m[d] >= 2 * dv + 2 * w * dv) begin
        rb = 1;
      end
    end
    return {bz, dn, err_m[d], sc, sd, rb};
  endfunction

  // Single compare process: advance the model at the edge, compare mid-cycle,
  // then let the PLL model react to what the DUT drove.
  initial begin
    for (int d = 0; d < 3; d++) begin
      act_m[d] = 0; fin_m[d] = 0; k_m[d] = 0; err_m[d] = 0; rd_m[d] = '0;
      ls1_m[d] = 0; ls2_m[d] = 0; prev_sclk[d] = 0; prev_rb[d] = 1;
    end
    forever begin
      @(posedge clk);
      for (int d = 0; d < 3; d++) model_step(d);
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 3; d++) begin
        logic [5:0] o;
        o = get_out(d);
        check($sformatf("d%0d_pins@%0d", d, cyc), 64'(o), 64'(model_out(d)));
        if (!act_m[d] || fin_m[d])
          check($sformatf("d%0d_rdata@%0d", d, cyc), get_rd(d), rd_m[d]);
        if (o[2] && !prev_sclk[d]) begin
          sclk_rises[d]++;
          pll_sr[d] = ((pll_sr[d] << 1) | 64'(o[1])) & mask(pw[d]);
        end
        if (o[2]) begin
          sclk_high[d]++;
          sdi_high[d] += int'(o[1]);
        end
        if (!o[0]) rb_low[d]++;
        if (o[0] && !prev_rb[d]) begin
          rb_rises[d]++;
          rise_cyc[d] = cyc;
        end
        if (o[4]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
        if (!o[5]) busy_low[d]++;
        prev_sclk[d] = o[2];
        prev_rb[d]   = o[0];
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_stats(input int d);
    sclk_rises[d] = 0; sclk_high[d] = 0; sdi_high[d] = 0; rb_low[d] = 0;
    rb_rises[d] = 0; done_cnt[d] = 0; busy_low[d] = 0;
  endtask

  function automatic int stat(input int d, input int sel);
    case (sel)
      0:       return done_cnt[d];
      1:       return sclk_rises[d];
      default: return rb_rises[d];
    endcase
  endfunction

  task automatic wait_for(input int d, input int sel, input int target,
                          input int maxc, input string nm);
    int n = 0;
    while (stat(d, sel) < target && n < maxc) begin
      tick();
      n++;
    end
    check(nm, 64'(stat(d, sel)), 64'(target));
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      start_v[d] = 0; cfg_v[d] = '0; lock_v[d] = 0; pll_sr[d] = '0;
      sclk_rises[d] = 0; sclk_high[d] = 0; sdi_high[d] = 0; rb_low[d] = 0;
      rb_rises[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0; rise_cyc[d] = 0;
      busy_low[d] = 0;
    end
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset_pins_d%0d", d), 64'(get_out(d)), 64'(6'b000001));
      check($sformatf("reset_rdata_d%0d", d), get_rd(d), 64'd0);
    end
    rst = 1'b0;
    tick();

    // Nominal transaction plus an ignored second START mid-shift.
    pll_sr[0] = 64'h0123_4567;
    cfg_v[0]  = 64'h2AAA_AAAA;
    clr_stats(0);
    pulse_start(0);
    repeat (49) tick();
    cfg_v[0] = 64'h1555_5555;
    pulse_start(0);
    wait_for(0, 2, 1, 400, "t1_resetb_rise");
    repeat (10) tick();
    lock_v[0] = 1'b1;
    wait_for(0, 0, 1, 100, "t1_done");
    repeat (5) tick();
    check("t1_sclk_rises", 64'(sclk_rises[0]), 64'd30);
    check("t1_pll_holds", pll_sr[0], 64'h2AAA_AAAA);
    check("t1_rdata", get_rd(0), 64'h0123_4567);
    check("t1_resetb_low", 64'(rb_low[0]), 64'd248);
    check("t1_done_count", 64'(done_cnt[0]), 64'd1);
    check("t1_error", 64'(if_a.error), 64'd0);
    lock_v[0] = 1'b0;

    // Asynchronous abort at the 10th SCLK rise, then a clean retry.
    cfg_v[0] = {$urandom, $urandom};
    clr_stats(0);
    pulse_start(0);
    wait_for(0, 1, 10, 300, "t2_tenth_rise");
    rst = 1'b1;
    #1;
    check("t2_async_reset_pins", 64'(get_out(0)), 64'(6'b000001));
    tick();
    rst = 1'b0;
    tick();
    lock_v[0] = 1'b1;
    clr_stats(0);
    pulse_start(0);
    wait_for(0, 0, 1, 400, "t2_recover_done");
    check("t2_recover_error", 64'(if_a.error), 64'd0);

    // START held through two back-to-back transactions.
    clr_stats(0);
    cfg_v[0]   = {$urandom, $urandom};
    start_v[0] = 1'b1;
    wait_for(0, 0, 2, 700, "t3_two_done");
    start_v[0] = 1'b0;
    check("t3_busy_low_cycles", 64'(busy_low[0]), 64'd2);
    lock_v[0] = 1'b0;
    repeat (3) tick();

    // Lock timeout on the short-timeout instance; error stays until next START.
    lock_v[1] = 1'b0;
    cfg_v[1]  = {$urandom, $urandom};
    clr_stats(1);
    pulse_start(1);
    wait_for(1, 0, 1, 200, "t4_done");
    check("t4_error_set", 64'(if_b.error), 64'd1);
    check("t4_timeout_latency", 64'(done_cyc[1] - rise_cyc[1]), 64'd16);
    repeat (20) tick();
    check("t4_error_sticky", 64'(if_b.error), 64'd1);
    lock_v[1] = 1'b1;
    pulse_start(1);
    check("t4_error_cleared", 64'(if_b.error), 64'd0);
    wait_for(1, 0, 2, 200, "t4_second_done");
    check("t4_error_after_lock", 64'(if_b.error), 64'd0);

    // Smallest configuration: one bit, one-cycle half periods.
    lock_v[2] = 1'b1;
    cfg_v[2]  = 64'd1;
    pll_sr[2] = 64'd0;
    clr_stats(2);
    pulse_start(2);
    wait_for(2, 0, 1, 50, "t5_done");
    check("t5_resetb_low", 64'(rb_low[2]), 64'd4);
    check("t5_sclk_high", 64'(sclk_high[2]), 64'd1);
    check("t5_sdi_while_high", 64'(sdi_high[2]), 64'd1);
    check("t5_pll_holds", pll_sr[2], 64'd1);
    check("t5_rdata", get_rd(2), 64'd0);

    // Random traffic on all instances, including one mid-run reset.
    for (int d = 0; d < 3; d++) begin
      pll_sr[d] = {$urandom, $urandom} & mask(pw[d]);
      clr_stats(d);
    end
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < 3; d++) begin
        start_v[d] = ($urandom_range(0, 15) == 0);
        cfg_v[d]   = {$urandom, $urandom};
        case (d)
          0:       lock_v[d] = ($urandom_range(0, 63) == 0);
          1:       lock_v[d] = ($urandom_range(0, 31) == 0);
          default: lock_v[d] = ($urandom_range(0, 3) == 0);
        endcase
      end
      rst = (n == 1500);
      tick();
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
    repeat (5) tick();
    for (int d = 0; d < 3; d++)
      check($sformatf("rand_activity_d%0d", d), 64'(done_cnt[d] != 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
